// File: rtl/sad_fifo_pkg.sv
// Shared definitions for the SAD fetch-path FIFO buffers.
package sad_fifo_pkg;

  typedef enum logic {
    FIFO_MODE_REG  = 1'b0,
    FIFO_MODE_FWFT = 1'b1
  } fifo_mode_e;

  // Occupancy needs one bit more than the pointers to represent DEPTH itself.
  function automatic int fifo_cw(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
module fifo_regfile #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO between pixel fetch and the SAD engines; registered or
// first-word-fall-through read, threshold flags, sticky error flags, flush.
module sync_fifo_param
  import sad_fifo_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 256,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         wr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         rd,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         rd_valid,
  output logic [fifo_cw(DEPTH)-1:0]    count,
  output logic                         empty,
  output logic                         full,
  output logic                         almost_empty,
  output logic                         almost_full,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = fifo_cw(DEPTH);
  localparam bit IS_FWFT = (FWFT == int'(FIFO_MODE_FWFT));

  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count_q;
  logic              ovf_q, unf_q;
  logic [DATA_W-1:0] rd_data_q, mem_rdata;
  logic              rd_valid_q;
  logic              empty_i, full_i;
  logic              rd_acc, wr_acc;

  assign empty_i = (count_q == '0);
  assign full_i  = (count_q == CW'(DEPTH));

  // Flush wins over any request in the same cycle.
  assign rd_acc = rd & ~empty_i & ~flush;
  assign wr_acc = wr & (~full_i | rd_acc) & ~flush;

  fifo_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_regfile (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (flush) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wr & ~wr_acc) ovf_q <= 1'b1;
      if (rd & empty_i) unf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (flush) begin
      rd_valid_q <= 1'b0;
    end else if (rd_acc) begin
      rd_data_q  <= mem_rdata;
      rd_valid_q <= 1'b1;
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

  // In FWFT mode an empty FIFO shows zero rather than stale or uninitialised storage.
  assign rd_data  = IS_FWFT ? (empty_i ? '0 : mem_rdata) : rd_data_q;
  assign rd_valid = IS_FWFT ? ~empty_i : rd_valid_q;

  assign count        = count_q;
  assign empty        = empty_i;
  assign full         = full_i;
  assign almost_full  = (int'(count_q) >= AF_LEVEL);
  assign almost_empty = (int'(count_q) <= AE_LEVEL);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a registered-read instance checked against a queue
// model, plus a first-word-fall-through instance.
module tb_sync_fifo_param;

  localparam int DW  = 8;
  localparam int DEP = 4;
  localparam int CW  = 3;
  localparam int AF  = 3;
  localparam int AE  = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          flush = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid, empty, full, almost_empty, almost_full, overflow, underflow;
  logic [CW-1:0] count;

  logic          f_flush = 1'b0, f_wr = 1'b0, f_rd = 1'b0;
  logic [DW-1:0] f_wr_data = '0;
  logic [DW-1:0] f_rd_data;
  logic          f_rd_valid, f_empty, f_full, f_almost_empty, f_almost_full, f_overflow, f_underflow;
  logic [CW-1:0] f_count;

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEP), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr(wr), .wr_data(wr_data), .rd(rd),
    .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEP), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_dut_fwft (
    .clk(clk), .rst_n(rst_n), .flush(f_flush), .wr(f_wr), .wr_data(f_wr_data), .rd(f_rd),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .count(f_count), .empty(f_empty), .full(f_full),
    .almost_empty(f_almost_empty), .almost_full(f_almost_full),
    .overflow(f_overflow), .underflow(f_underflow)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] sb_q [$];
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic chk_status();
    int sz;
    sz = sb_q.size();
    chk("count", 32'(count), 32'(sz));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("full", 32'(full), 32'(sz == DEP));
    chk("almost_full", 32'(almost_full), 32'(sz >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(sz <= AE));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
  endtask

  // One clock of stimulus on the registered instance, then compare with the model.
  task automatic cycle(input logic f, input logic w, input logic r, input logic [DW-1:0] d);
    bit r_acc, w_acc;
    logic [DW-1:0] exp_d;
    exp_d = '0;
    r_acc = !f && r && (sb_q.size() > 0);
    w_acc = !f && w && ((sb_q.size() < DEP) || r_acc);
    flush = f; wr = w; rd = r; wr_data = d;
    @(posedge clk); #1;
    flush = 1'b0; wr = 1'b0; rd = 1'b0;
    if (f) begin
      sb_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (w && !w_acc) m_ovf = 1'b1;
      if (r && sb_q.size() == 0) m_unf = 1'b1;
      if (r_acc) exp_d = sb_q.pop_front();
      if (w_acc) sb_q.push_back(d);
    end
    chk("rd_valid", 32'(rd_valid), 32'(r_acc));
    if (r_acc) chk("rd_data", 32'(rd_data), 32'(exp_d));
    chk_status();
  endtask

  task automatic chk_reset_values();
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_almost_empty", 32'(almost_empty), 1);
    chk("rst_almost_full", 32'(almost_full), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_underflow", 32'(underflow), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_f_rd_valid", 32'(f_rd_valid), 0);
    chk("rst_f_rd_data", 32'(f_rd_data), 0);
    chk("rst_f_count", 32'(f_count), 0);
  endtask

  initial begin
    #12;
    chk_reset_values();
    @(negedge clk) rst_n = 1'b1;

    // fill, then one write too many
    cycle(0, 1, 0, 8'h11);
    cycle(0, 1, 0, 8'h22);
    cycle(0, 1, 0, 8'h33);
    cycle(0, 1, 0, 8'h44);
    chk("full_after_4", 32'(full), 1);
    cycle(0, 1, 0, 8'h55);
    chk("ovf_count_4", 32'(count), 4);

    // drain in order, then pop an empty FIFO
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 8'h00);
    cycle(0, 0, 1, 8'h00);
    chk("unf_set", 32'(underflow), 1);

    // wrap-around with interleaved write/pop pairs
    cycle(1, 0, 0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 0, 8'(i));
      cycle(0, 0, 1, 8'h00);
    end

    // simultaneous read+write at full
    for (int i = 1; i <= 4; i++) cycle(0, 1, 0, 8'(i));
    cycle(0, 1, 1, 8'hAA);
    chk("full_rw_count", 32'(count), 4);
    chk("full_rw_no_ovf", 32'(overflow), 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 8'h00);
    chk("aa_read_last", 32'(rd_data), 32'h0AA);

    // simultaneous read+write at empty
    cycle(0, 1, 1, 8'h77);
    chk("empty_rw_count", 32'(count), 1);
    chk("empty_rw_unf", 32'(underflow), 1);

    // flush with count=3 while writing
    cycle(0, 1, 0, 8'h78);
    cycle(0, 1, 0, 8'h79);
    cycle(1, 1, 0, 8'h7A);
    chk("flush_count", 32'(count), 0);
    cycle(0, 1, 0, 8'hC1);
    cycle(0, 0, 1, 8'h00);

    // reset asserted mid-burst, checked before the next edge
    cycle(0, 1, 0, 8'hD1);
    cycle(0, 1, 0, 8'hD2);
    cycle(0, 1, 1, 8'hD3);
    cycle(0, 1, 0, 8'hD4);
    #1 rst_n = 1'b0;
    #1;
    chk_reset_values();
    sb_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    cycle(0, 0, 1, 8'h00);
    chk("post_rst_unf", 32'(underflow), 1);

    // first-word-fall-through instance
    @(negedge clk);
    f_wr = 1'b1; f_wr_data = 8'h5A;
    @(posedge clk); #1;
    f_wr = 1'b0;
    chk("fwft_data", 32'(f_rd_data), 32'h05A);
    chk("fwft_valid", 32'(f_rd_valid), 1);
    @(posedge clk); #1;
    chk("fwft_hold", 32'(f_rd_data), 32'h05A);
    chk("fwft_hold_cnt", 32'(f_count), 1);
    f_wr = 1'b1; f_wr_data = 8'h3C;
    @(posedge clk); #1;
    f_wr = 1'b0;
    chk("fwft_head", 32'(f_rd_data), 32'h05A);
    chk("fwft_cnt2", 32'(f_count), 2);
    f_rd = 1'b1;
    @(posedge clk); #1;
    chk("fwft_pop1_data", 32'(f_rd_data), 32'h03C);
    chk("fwft_pop1_valid", 32'(f_rd_valid), 1);
    @(posedge clk); #1;
    f_rd = 1'b0;
    chk("fwft_pop2_valid", 32'(f_rd_valid), 0);
    chk("fwft_pop2_empty", 32'(f_empty), 1);
    chk("fwft_no_unf", 32'(f_underflow), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
